mos_decoder_sequencer: RTL and testbench

MOS_DECODER_SEQUENCER -- requirements
Module: mos_decoder_sequencer

---
 rtl/mos_decoder_sequencer.sv | 141 ++++++++++++++
 tb/tb_mos_decoder_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mos_decoder_sequencer.sv
// Drives opcodes into a MOS decoder, waits SETTLE_CYCLES, then captures its result (single opcode or full 0x00..0xFF sweep).
// Optional build macro MOS_SEQ_SIGNATURE_EN adds a 32-bit running signature of every capture.
`timescale 1ns/1ps
module mos_decoder_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  cmd_instr_i,
  input  logic        cmd_start_i,
  input  logic        cmd_sweep_i,
  output logic [7:0]  decoder_instr_o,
  input  logic [65:0] decoder_result_i,
  output logic [65:0] result_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] signature_o
);

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sweep_q, sweep_d;
  logic [7:0]  instr_q, instr_d;
  logic [65:0] result_q, result_d;
  logic        done_q, done_d;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      sweep_q  <= 1'b0;
      instr_q  <= 8'h00;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sweep_q  <= sweep_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_d  = sweep_q;
    instr_d  = instr_q;
    result_d = result_q;
    done_d   = done_q;
    case (state_q)
      IDLE: begin
        // Sweep takes priority when both requests arrive together.
        if (cmd_sweep_i) begin
          instr_d = 8'h00;
          sweep_d = 1'b1;
          cnt_d   = CNT_RELOAD;
          done_d  = 1'b0;
          state_d = SETTLE;
        end else if (cmd_start_i) begin
          instr_d = cmd_instr_i;
          sweep_d = 1'b0;
          cnt_d   = CNT_RELOAD;
          done_d  = 1'b0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        result_d = decoder_result_i;
        if (!sweep_q || (instr_q == 8'hFF)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          instr_d = instr_q + 8'd1;
          cnt_d   = CNT_RELOAD;
          state_d = SETTLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign decoder_instr_o = instr_q;
  assign result_o        = result_q;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;

`ifdef MOS_SEQ_SIGNATURE_EN
  logic [31:0] sig_q, sig_d;
  logic        sig_clr;
  logic        sig_upd;

  function automatic logic [31:0] sig_fold(input logic [31:0] sig, input logic [65:0] r);
    return {sig[30:0], sig[31]} ^ (r[31:0] ^ r[63:32] ^ {30'b0, r[65:64]});
  endfunction

  // Cleared on exactly the same condition that accepts a command in IDLE.
  assign sig_clr = (state_q == IDLE) && (cmd_sweep_i || cmd_start_i);
  assign sig_upd = (state_q == CAPTURE);

  always_comb begin
    sig_d = sig_q;
    if (sig_clr) begin
      sig_d = 32'h0;
    end else if (sig_upd) begin
      sig_d = sig_fold(sig_q, decoder_result_i);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sig_q <= 32'h0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature_o = sig_q;
`else
  assign signature_o = 32'h0;
`endif

endmodule

// File: tb/tb_mos_decoder_sequencer.sv
// Scoreboard bench for mos_decoder_sequencer: stimulus pushes modelled completions, a monitor pops them on done_o rising.
`timescale 1ns/1ps
module tb_mos_decoder_sequencer;

  localparam int SC = 2;

`ifdef MOS_SEQ_SIGNATURE_EN
  localparam bit SIG_EN = 1'b1;
`else
  localparam bit SIG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd_instr = 8'h00;
  logic        cmd_start = 1'b0;
  logic        cmd_sweep = 1'b0;
  logic [7:0]  dec_instr;
  logic [65:0] dec_result;
  logic [65:0] result;
  logic        busy;
  logic        done;
  logic [31:0] sig;

  typedef struct {
    logic [65:0] result;
    logic [7:0]  instr;
    logic [31:0] sig;
    int          busy_len;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [65:0] stub(input logic [7:0] op);
    return {2'b10, 24'h0, op, 24'h0, op};
  endfunction

  assign dec_result = stub(dec_instr);

  mos_decoder_sequencer #(.SETTLE_CYCLES(SC)) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .cmd_instr_i     (cmd_instr),
    .cmd_start_i     (cmd_start),
    .cmd_sweep_i     (cmd_sweep),
    .decoder_instr_o (dec_instr),
    .decoder_result_i(dec_result),
    .result_o        (result),
    .busy_o          (busy),
    .done_o          (done),
    .signature_o     (sig)
  );

  // Reference model: signature is a rotate-and-xor fold of the captured words.
  function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [65:0] r);
    logic [31:0] folded;
    folded = r[31:0] ^ r[63:32] ^ {30'b0, r[65:64]};
    return {s[30:0], s[31]} ^ folded;
  endfunction

  function automatic exp_t model_single(input logic [7:0] op);
    exp_t e;
    e.result   = stub(op);
    e.instr    = op;
    e.sig      = SIG_EN ? sig_step(32'h0, stub(op)) : 32'h0;
    e.busy_len = SC + 1;
    return e;
  endfunction

  function automatic exp_t model_sweep();
    exp_t e;
    logic [31:0] s;
    s = 32'h0;
    for (int op = 0; op < 256; op++) s = sig_step(s, stub(8'(op)));
    e.result   = stub(8'hFF);
    e.instr    = 8'hFF;
    e.sig      = SIG_EN ? s : 32'h0;
    e.busy_len = 256 * (SC + 1);
    return e;
  endfunction

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: tracks busy length and opcode hold time, pops the scoreboard on done rising.
  initial begin
    logic busy_p = 1'b0;
    logic done_p = 1'b0;
    int   blen   = 0;
    int   run    = 0;
    logic [7:0] run_op = 8'h00;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_p = 1'b0;
        done_p = 1'b0;
        blen   = 0;
        run    = 0;
        continue;
      end
      if (busy) begin
        if (!busy_p) begin
          blen   = 1;
          run    = 1;
          run_op = dec_instr;
        end else begin
          blen++;
          if (dec_instr !== run_op) begin
            check("instr_step", 66'(dec_instr), 66'(run_op) + 66'd1);
            check("instr_hold", 66'(run), 66'(SC + 1));
            run    = 1;
            run_op = dec_instr;
          end else begin
            run++;
          end
        end
      end else if (busy_p) begin
        check("instr_hold_last", 66'(run), 66'(SC + 1));
      end
      if (done && !done_p) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with empty scoreboard, expected none (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", result, e.result);
          check("sb_instr", 66'(dec_instr), 66'(e.instr));
          check("sb_signature", 66'(sig), 66'(e.sig));
          check("sb_busy_len", 66'(blen), 66'(e.busy_len));
        end
      end
      busy_p = busy;
      done_p = done;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] op);
    cmd_instr = op;
    cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
  endtask

  task automatic pulse_sweep();
    cmd_sweep = 1'b1;
    cyc();
    cmd_sweep = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      cyc();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got busy after %0d cycles, expected idle", budget);
    end
  endtask

  initial begin
    logic [7:0] op;
    int         n;
    int         kind;
    exp_t       e;

    // Reset held two cycles.
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_instr", 66'(dec_instr), 66'h0);
    check("rst_result", result, 66'h0);
    check("rst_busy", 66'(busy), 66'h0);
    check("rst_done", 66'(done), 66'h0);
    check("rst_sig", 66'(sig), 66'h0);
    rst = 1'b0;
    cyc();

    // Single capture of 0xA9 with exact timing.
    exp_q.push_back(model_single(8'hA9));
    pulse_start(8'hA9);
    check("single_instr_e1", 66'(dec_instr), 66'hA9);
    check("single_busy_e1", 66'(busy), 66'h1);
    cyc();
    cyc();
    check("single_busy_e2", 66'(busy), 66'h1);
    check("single_done_e2", 66'(done), 66'h0);
    cyc();
    check("single_result_e3", result, 66'h2_0000_00A9_0000_00A9);
    check("single_done_e3", 66'(done), 66'h1);
    check("single_busy_e3", 66'(busy), 66'h0);
    check("single_sig_e3", 66'(sig), SIG_EN ? 66'h2 : 66'h0);
    cyc();

    // Full sweep.
    exp_q.push_back(model_sweep());
    pulse_sweep();
    wait_idle(1000);
    check("sweep_final_instr", 66'(dec_instr), 66'hFF);
    check("sweep_final_result", result, 66'h2_0000_00FF_0000_00FF);
    check("sweep_done", 66'(done), 66'h1);
    cyc();

    // Start and sweep together: sweep wins; a mid-sweep start is ignored.
    exp_q.push_back(model_sweep());
    cmd_instr = 8'h33;
    cmd_start = 1'b1;
    cmd_sweep = 1'b1;
    cyc();
    cmd_start = 1'b0;
    cmd_sweep = 1'b0;
    repeat ($urandom_range(100, 600)) cyc();
    pulse_start(8'($urandom));
    wait_idle(1000);
    cyc();

    // Reset at cycle 100 of a sweep aborts it silently.
    pulse_sweep();
    repeat (99) cyc();
    check("abort_busy_before", 66'(busy), 66'h1);
    rst = 1'b1;
    cyc();
    check("abort_busy", 66'(busy), 66'h0);
    check("abort_done", 66'(done), 66'h0);
    check("abort_instr", 66'(dec_instr), 66'h0);
    check("abort_result", result, 66'h0);
    check("abort_sig", 66'(sig), 66'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cyc();

    // Back-to-back: second start the cycle after done rises.
    exp_q.push_back(model_single(8'h5E));
    pulse_start(8'h5E);
    n = 0;
    while (!done && n < 20) begin
      cyc();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL b2b_done_timeout: got done=0, expected done=1 within 20 cycles");
    end
    exp_q.push_back(model_single(8'h4C));
    pulse_start(8'h4C);
    check("b2b_done_cleared", 66'(done), 66'h0);
    cyc();
    cyc();
    check("b2b_done_low_e2", 66'(done), 66'h0);
    cyc();
    check("b2b_done_e3", 66'(done), 66'h1);
    check("b2b_result", result, stub(8'h4C));
    cyc();

    // Randomised traffic.
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) cyc();
      kind = int'($urandom_range(0, 7));
      op   = 8'($urandom);
      if (kind == 0) begin
        exp_q.push_back(model_sweep());
        cmd_sweep = 1'b1;
        cmd_start = $urandom_range(0, 1) == 1;
        cmd_instr = op;
        cyc();
        cmd_sweep = 1'b0;
        cmd_start = 1'b0;
      end else begin
        e = model_single(op);
        exp_q.push_back(e);
        pulse_start(op);
        if (kind == 1) begin
          cmd_start = 1'b1;
          cmd_instr = ~op;
          cyc();
          cmd_start = 1'b0;
        end
      end
      wait_idle(1000);
    end

    cyc();
    cyc();
    check("scoreboard_drained", 66'(exp_q.size()), 66'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
